dac_spi_receiver: RTL and testbench
===================================

# dac_spi_receiver

SPI target (receiver) that deserialises 24-bit frames driven by the DAC SPI master and presents each completed word on a parallel bus with a one-cycle valid strobe. It runs entirely in the FPGA `clock_in` domain and oversamples the SPI pins, which are asynchronous to it. It serves as the loopback/self-check endpoint for the DAC link on the board and as a DAC behavioural stand-in for bench and hardware checks.

## Interface
Parameters:
- WORD_BITS, 24, frame length in bits, MSB first
- SYNC_STAGES, 2, flip-flop stages on each SPI input (minimum 2)

Ports:
- clock_in  input  1  system clock (133 MHz nominal); one clock
- reset  input  1  asynchronous, active-high reset
- spi_cs_in  input  1  chip select, active low
- spi_clock_in  input  1  SPI clock, idle low, data sampled on rising edge (mode 0)
- spi_data_in  input  1  serial data, MSB first
- data_out  output  WORD_BITS  last good frame, held until next good frame
- data_valid  output  1  one-cycle pulse when data_out updates
- frame_error  output  1  one-cycle pulse on a bad frame
- busy  output  1  high while a frame is in progress (synchronised CS low)

## Operation
- All three SPI inputs pass through SYNC_STAGES flops; CS and SCLK additionally feed a one-flop history register for edge detection. Data is sampled from the synchronised data line on the cycle a synchronised SCLK rising edge is detected.
- State machine:
  - WAIT_IDLE: entered from reset. Leaves for IDLE once synchronised CS is high. This blocks capture of a frame already in flight at reset release.
  - IDLE: on a CS falling edge, clear the shift register and bit_count, then go to SHIFT. SCLK edges are ignored here.
  - SHIFT: on each SCLK rise, shift the data bit in at the LSB and increment bit_count. When bit_count reaches WORD_BITS, go to FULL.
    - On a CS rise with bit_count < WORD_BITS: pulse frame_error, go to IDLE, leave data_out unchanged.
  - FULL: on a CS rise, load data_out, pulse data_valid, go to IDLE.
    - Any further SCLK rise sets an overrun flag; extra bits are not shifted in.
    - On a CS rise with overrun set: pulse frame_error instead of data_valid, leave data_out unchanged, then go to IDLE.
- bit_count is sized ceil(log2(WORD_BITS+1)) and saturates at WORD_BITS.
- A CS fall and an SCLK rise detected in the same cycle: the SCLK rise is ignored. The master must provide at least one SCLK half-period of CS-to-clock setup.
- Reset values: data_out = 0, data_valid = 0, frame_error = 0, busy = 0, state = WAIT_IDLE, all sync flops = 0.
- Reset asserted mid-frame aborts the frame with no strobes. After release, the block waits in WAIT_IDLE until CS is high.

## Timing
- Maximum SPI clock is clock_in/8; each SCLK high and low phase must be at least 3 clock_in cycles.
- Latency: data_valid and data_out update together, SYNC_STAGES+2 clock_in edges after the first edge that samples spi_cs_in high. This is 4 cycles at default parameters.
- frame_error has the same latency as data_valid. The two are never asserted together.
- busy follows synchronised CS, delayed SYNC_STAGES+1 cycles after the pin.
- Back-to-back frames need CS high for at least 2 clock_in cycles after synchronisation; a shorter CS-high pulse may be missed.

## Structure
- Shared package `dac_spi_pkg` holds:
  - DAC_WORD_BITS = 24, also used by the DAC master
  - the receiver state enum (WAIT_IDLE, IDLE, SHIFT, FULL)
  - SYNC_STAGES default
- Sub-module `spi_input_sync` provides a parameterised synchroniser with rise/fall outputs. It is instantiated for CS and SCLK; data uses the synchroniser alone.

## Test plan
- Drive the DAC master with 24'hB155CC, then 24'hB155CD, 2000 ns apart. Required: two data_valid pulses with data_out = B155CC then B155CD, and no frame_error.
- Send a 23-bit frame, then CS high. Required: one frame_error pulse, no data_valid, data_out keeps the previous value.
- Send a 25-bit frame (24'hB155CC followed by one extra 1 bit). Required: frame_error, no data_valid, data_out unchanged.
- Toggle SCLK and data while CS is high. Required: no strobes, busy = 0.
- Assert reset after 12 bits, then release with CS still low and finish the frame. Required: no strobes for that frame; the next full frame of 24'h000001 gives data_valid with data_out = 000001.
- At clock_in/8 SCLK, measure data_valid latency from the CS rise. Required: exactly 4 clock_in cycles with SYNC_STAGES = 2.

Source files
------------

// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC SPI link: word length, synchroniser depth
// and the receiver state encoding.
package dac_spi_pkg;

    localparam int DAC_WORD_BITS       = 24;
    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        FULL      = 2'd3
    } rx_state_e;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with registered
// single-cycle rise and fall pulses derived from the synchronised level.
module spi_input_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_hist;
    logic              r_rise;
    logic              r_fall;

    // Synchroniser chain, one-flop history and registered edge pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {STAGES{1'b0}};
            r_hist <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_hist <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_hist;
            r_fall <= ~r_sync[STAGES-1] & r_hist;
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/dac_spi_receiver.sv
// Oversampling SPI target: deserialises MSB-first frames from the DAC master
// and presents each good frame on a parallel bus with a one-cycle strobe.
module dac_spi_receiver
    import dac_spi_pkg::*;
#(
    parameter int WORD_BITS   = DAC_WORD_BITS,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 spi_cs_in,
    input  logic                 spi_clock_in,
    input  logic                 spi_data_in,
    output logic [WORD_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WORD_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic w_cs_sync, w_cs_rise, w_cs_fall;
    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_data_sync;
    logic w_unused_sclk;

    logic [SYNC_STAGES-1:0] r_data_sync;
    rx_state_e              r_state;
    logic [WORD_BITS-1:0]   r_shift;
    logic [CNT_W-1:0]       r_bit_count;
    logic                   r_overrun;
    logic [WORD_BITS-1:0]   r_data_out;
    logic                   r_data_valid;
    logic                   r_frame_error;
    logic                   r_busy;

    spi_input_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .i_clk   (clock_in),
        .i_rst   (reset),
        .i_async (spi_cs_in),
        .o_sync  (w_cs_sync),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .i_clk   (clock_in),
        .i_rst   (reset),
        .i_async (spi_clock_in),
        .o_sync  (w_sclk_sync),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    // Only the SCLK rising edge drives the shifter
    assign w_unused_sclk = w_sclk_sync ^ w_sclk_fall;

    // Data line synchroniser; no edge detection needed
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_data_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], spi_data_in};
        end
    end

    assign w_data_sync = r_data_sync[SYNC_STAGES-1];

    // Frame state machine with registered output strobes
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state       <= WAIT_IDLE;
            r_shift       <= {WORD_BITS{1'b0}};
            r_bit_count   <= {CNT_W{1'b0}};
            r_overrun     <= 1'b0;
            r_data_out    <= {WORD_BITS{1'b0}};
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= ~w_cs_sync & (r_state != WAIT_IDLE);
            case (r_state)
                WAIT_IDLE: begin
                    if (w_cs_sync) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    // A simultaneous SCLK rise is deliberately dropped here
                    if (w_cs_fall) begin
                        r_shift     <= {WORD_BITS{1'b0}};
                        r_bit_count <= {CNT_W{1'b0}};
                        r_overrun   <= 1'b0;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_cs_rise) begin
                        r_frame_error <= 1'b1;
                        r_state       <= IDLE;
                    end else if (w_sclk_rise) begin
                        r_shift <= {r_shift[WORD_BITS-2:0], w_data_sync};
                        if (r_bit_count != CNT_FULL) begin
                            r_bit_count <= r_bit_count + CNT_ONE;
                        end
                        if (r_bit_count == CNT_FULL - CNT_ONE) begin
                            r_state <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (w_cs_rise) begin
                        if (r_overrun) begin
                            r_frame_error <= 1'b1;
                        end else begin
                            r_data_out   <= r_shift;
                            r_data_valid <= 1'b1;
                        end
                        r_state <= IDLE;
                    end else if (w_sclk_rise) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state <= WAIT_IDLE;
                end
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign frame_error = r_frame_error;
    assign busy        = r_busy;

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Self-checking bench for dac_spi_receiver: table of frames driven through a
// mode-0 SPI master model, strobes checked against a scoreboard queue.
module tb_dac_spi_receiver;

    logic        clock_in = 1'b0;
    logic        reset;
    logic        spi_cs_in;
    logic        spi_clock_in;
    logic        spi_data_in;
    logic [23:0] data_out;
    logic        data_valid;
    logic        frame_error;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        int          reset_at;
        logic        exp_valid;
        logic        exp_err;
        logic [23:0] exp_hold;
    } vec_t;

    typedef struct {
        logic        v;
        logic        e;
        logic [23:0] d;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[8];

    dac_spi_receiver dut (
        .clock_in     (clock_in),
        .reset        (reset),
        .spi_cs_in    (spi_cs_in),
        .spi_clock_in (spi_clock_in),
        .spi_data_in  (spi_data_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    always #4 clock_in = ~clock_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Strobe monitor: every data_valid / frame_error pulse must match the queue head
    always @(negedge clock_in) begin
        sb_t s;
        if (data_valid === 1'b1 || frame_error === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, data_valid, frame_error}, 32'd0);
            end else begin
                s = sb_q.pop_front();
                check("strobe_kind", {30'd0, data_valid, frame_error}, {30'd0, s.v, s.e});
                if (s.v) check("strobe_data", {8'd0, data_out}, {8'd0, s.d});
            end
        end
    end

    task automatic send(input vec_t v);
        int lat;
        spi_cs_in = 1'b0;
        repeat (4) @(negedge clock_in);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        for (int i = v.nbits - 1; i >= 0; i--) begin
            if ((v.nbits - 1 - i) == v.reset_at) begin
                reset = 1'b1;
                repeat (3) @(negedge clock_in);
                check("midreset_data_out", {8'd0, data_out}, 32'd0);
                check("midreset_flags", {29'd0, busy, data_valid, frame_error}, 32'd0);
                reset = 1'b0;
                repeat (2) @(negedge clock_in);
            end
            spi_data_in = v.bits[i];
            repeat (4) @(negedge clock_in);
            spi_clock_in = 1'b1;
            repeat (4) @(negedge clock_in);
            spi_clock_in = 1'b0;
        end
        repeat (4) @(negedge clock_in);
        if (v.exp_valid || v.exp_err) sb_q.push_back('{v: v.exp_valid, e: v.exp_err, d: v.exp_hold});
        spi_cs_in = 1'b1;
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock_in);
            if (data_valid === 1'b1 || frame_error === 1'b1) begin
                lat = c;
                break;
            end
        end
        if (v.exp_valid || v.exp_err) check("strobe_latency", 32'(lat), 32'd4);
        repeat (240) @(negedge clock_in);
        check("data_out_hold", {8'd0, data_out}, {8'd0, v.exp_hold});
        check("busy_after_frame", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h00B155CC, 24, -1, 1'b1, 1'b0, 24'hB155CC};
        vecs[1] = '{32'h00B155CD, 24, -1, 1'b1, 1'b0, 24'hB155CD};
        vecs[2] = '{32'h002AAAAA, 23, -1, 1'b0, 1'b1, 24'hB155CD};
        vecs[3] = '{32'h0162AB99, 25, -1, 1'b0, 1'b1, 24'hB155CD};
        vecs[4] = '{32'h00A5A5A5, 24, 12, 1'b0, 1'b0, 24'h000000};
        vecs[5] = '{32'h00000001, 24, -1, 1'b1, 1'b0, 24'h000001};
        vecs[6] = '{32'h00FFFFFF, 24, -1, 1'b1, 1'b0, 24'hFFFFFF};
        vecs[7] = '{32'h00123456, 24, -1, 1'b1, 1'b0, 24'h123456};

        reset        = 1'b1;
        spi_cs_in    = 1'b1;
        spi_clock_in = 1'b0;
        spi_data_in  = 1'b0;
        repeat (3) @(negedge clock_in);
        check("reset_data_out", {8'd0, data_out}, 32'd0);
        check("reset_flags", {29'd0, busy, data_valid, frame_error}, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clock_in);

        // SCLK and data activity with CS high must be ignored
        for (int k = 0; k < 8; k++) begin
            spi_data_in  = 1'($urandom_range(0, 1));
            spi_clock_in = 1'b1;
            repeat (4) @(negedge clock_in);
            check("busy_cs_high", {31'd0, busy}, 32'd0);
            spi_clock_in = 1'b0;
            repeat (4) @(negedge clock_in);
        end

        for (int n = 0; n < 8; n++) begin
            send(vecs[n]);
        end

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
